ysyx_22040632_div_ctrl: RTL

YSYX_22040632_DIV_CTRL -- requirements
Module: ysyx_22040632_div_ctrl

---
 rtl/ysyx_22040632_div_ctrl_pkg.sv | 41 ++++
 rtl/ysyx_22040632_divif.sv | 21 ++
 rtl/ysyx_22040632_div_step.sv | 28 ++
 rtl/ysyx_22040632_div_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ysyx_22040632_div_ctrl_pkg.sv
// Shared types and constants for the 32-bit RV64M divide unit.
//   div_op_e    : divide/remainder operation encoding from the decoder
//   div_state_e : divide controller FSM states
//   DIV_ITER    : number of restoring shift-subtract iterations
// Helper functions cover op classification, 32-bit negation and
// sign-extension of a 32-bit result to the 64-bit writeback width.
package ysyx_22040632_RISCV_PKG;

    typedef enum logic [1:0] {
        DIV_W  = 2'b00,
        DIVU_W = 2'b01,
        REM_W  = 2'b10,
        REMU_W = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_e;

    localparam int unsigned DIV_ITER = 32;

    function automatic logic is_signed_op(input div_op_e o);
        return (o == DIV_W) || (o == REM_W);
    endfunction

    function automatic logic is_rem_op(input div_op_e o);
        return (o == REM_W) || (o == REMU_W);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22040632_divif.sv
// Decoder <-> divide controller handshake bundle.
//   in_valid/op/src1/src2/flush : decoder to divider
//   in_ready/busy/out_valid/result : divider to decoder / writeback
interface ysyx_22040632_divif;
    import ysyx_22040632_RISCV_PKG::*;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic [63:0] result;
    logic        busy;

    modport dec (output in_valid, op, src1, src2, flush,
                 input  in_ready, out_valid, result, busy);
    modport div (input  in_valid, op, src1, src2, flush,
                 output in_ready, out_valid, result, busy);
endinterface

// File: rtl/ysyx_22040632_div_step.sv
// One restoring shift-subtract step (combinational).
//   rem_i/quo_i : partial remainder and quotient/dividend shift register
//   dvs_i       : divisor magnitude
//   rem_o/quo_o : values after shifting {rem,quo} left and a trial subtract
module ysyx_22040632_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);
    logic [32:0] partial;
    logic [32:0] diff;

    always_comb begin
        partial = {rem_i, quo_i[31]};
        diff    = partial - {1'b0, dvs_i};
        // Bit 32 of the difference is the borrow: set means partial < divisor,
        // in which case partial itself fits in 32 bits.
        if (!diff[32]) begin
            rem_o = diff[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = partial[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end
endmodule

// File: rtl/ysyx_22040632_div_ctrl.sv
// Multi-cycle controller for RV64M divw/divuw/remw/remuw.
//   clk, rrst_n (async, active-low)
//   in_valid/in_ready : op handshake (accept only in IDLE, flush wins)
//   op, src1, src2    : operation and operands (low 32 bits used)
//   flush             : abort any in-flight op without a result
//   out_valid         : one-cycle pulse in DONE
//   result            : sign-extended 32-bit result, held until next result
//   busy              : high outside IDLE
module ysyx_22040632_div_ctrl
    import ysyx_22040632_RISCV_PKG::*;
(
    input  logic        clk,
    input  logic        rrst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] result,
    output logic        busy
);
    div_state_e  state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    div_op_e     op_q,     op_d;
    logic [31:0] rem_q,    rem_d;
    logic [31:0] quo_q,    quo_d;
    logic [31:0] dvs_q,    dvs_d;
    logic        qneg_q,   qneg_d;
    logic        rneg_q,   rneg_d;
    logic [63:0] result_q, result_d;

    div_op_e     op_in;
    logic        s1, s2;
    logic [31:0] a, b, mag1, mag2;
    logic [31:0] step_rem, step_quo;
    logic [31:0] q_fix, r_fix;
    logic        accept;
    logic        unused_hi;

    assign unused_hi = ^{src1[63:32], src2[63:32]};

    assign op_in  = div_op_e'(op);
    assign a      = src1[31:0];
    assign b      = src2[31:0];
    assign s1     = is_signed_op(op_in) & a[31];
    assign s2     = is_signed_op(op_in) & b[31];
    assign mag1   = s1 ? neg32(a) : a;
    assign mag2   = s2 ? neg32(b) : b;
    assign accept = in_valid && (state_q == S_IDLE) && !flush;

    ysyx_22040632_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign q_fix = qneg_q ? neg32(quo_q) : quo_q;
    assign r_fix = rneg_q ? neg32(rem_q) : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_d   = op_in;
                        cnt_d  = '0;
                        qneg_d = s1 ^ s2;
                        rneg_d = s1;
                        if (b == '0) begin
                            result_d = sext32(is_rem_op(op_in) ? a : 32'hFFFF_FFFF);
                            state_d  = S_DONE;
                        end else if (is_signed_op(op_in) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            result_d = sext32(is_rem_op(op_in) ? 32'h0 : 32'h8000_0000);
                            state_d  = S_DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = mag1;
                            dvs_d   = mag2;
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_ITER - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = sext32(is_rem_op(op_q) ? r_fix : q_fix);
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= DIV_W;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = !in_ready;
    // A flush arriving in DONE kills that cycle's writeback.
    assign out_valid = (state_q == S_DONE) && !flush;
    assign result    = result_q;

endmodule
